// File: rtl/pdm_multi.sv
// pdm_multi: multi-channel first-order sigma-delta PDM output stage.
// Channels share an update divider and commit their shadow duty registers on the same tick.
module pdm_multi #(
  parameter int W = 16,
  parameter int NCH = 2,
  parameter int DIV_W = 4,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [NCH-1:0]   en,
  input  logic             wr_valid,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [W-1:0]     wr_data,
  output logic             sample_req,
  output logic [NCH-1:0]   pdm
);
  logic [DIV_W-1:0] cnt, div_q;
  logic [W-1:0] shadow [NCH];
  logic [W-1:0] active [NCH];
  logic [W-1:0] acc [NCH];
  logic [W:0] sum [NCH];
  logic tick;
  assign tick = cnt == div_q;
  // MSB inversion turns the signed duty into offset binary before accumulation
  always_comb
    for (int i = 0; i < NCH; i++)
      sum[i] = {1'b0, acc[i]} + {1'b0, ~active[i][W-1], active[i][W-2:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      div_q <= '0;
      sample_req <= 1'b0;
      pdm <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) div_q <= div;
      sample_req <= tick;
      for (int i = 0; i < NCH; i++) begin
        if (wr_valid && wr_ch == CH_W'(i)) shadow[i] <= wr_data;
        if (tick) active[i] <= shadow[i];
        if (!en[i]) begin
          acc[i] <= '0;
          pdm[i] <= 1'b0;
        end else if (tick) begin
          acc[i] <= sum[i][W-1:0];
          pdm[i] <= sum[i][W];
        end
      end
    end
endmodule

// File: tb/tb_pdm_multi.sv
// tb_pdm_multi: scoreboard bench for pdm_multi (W=8, NCH=3 so wr_ch can address a missing channel).
module tb_pdm_multi;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] div = 4'd3;
  logic [2:0] en = 3'b111;
  logic wr_valid = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic sample_req;
  logic [2:0] pdm;
  int total = 0, bad = 0;
  logic [3:0] q[$];
  int m_cnt, m_divq, m_shadow[3], m_active[3], m_acc[3];
  logic [2:0] m_pdm;
  logic m_sreq;

  pdm_multi #(.W(8), .NCH(3), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .div(div), .en(en), .wr_valid(wr_valid),
    .wr_ch(wr_ch), .wr_data(wr_data), .sample_req(sample_req), .pdm(pdm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_divq = 0; m_pdm = '0; m_sreq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_shadow[c] = 0; m_active[c] = 0; m_acc[c] = 0;
    end
    q.delete();
  endtask

  // reference behaviour of one clock edge, using the inputs currently driven
  task automatic model_edge();
    automatic bit tick = (m_cnt == m_divq);
    automatic int s;
    m_sreq = tick;
    for (int c = 0; c < 3; c++) begin
      if (!en[c]) begin
        m_acc[c] = 0; m_pdm[c] = 1'b0;
      end else if (tick) begin
        s = m_acc[c] + ((m_active[c] + 128) % 256);
        m_acc[c] = s % 256; m_pdm[c] = (s >= 256);
      end
    end
    if (tick) for (int c = 0; c < 3; c++) m_active[c] = m_shadow[c];
    if (wr_valid && wr_ch < 3) m_shadow[wr_ch] = int'(wr_data);
    m_cnt = tick ? 0 : (m_cnt + 1) % 16;
    if (tick) m_divq = int'(div);
  endtask

  task automatic step();
    automatic logic [3:0] e;
    model_edge();
    q.push_back({m_sreq, m_pdm});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pdm", int'(pdm), int'(e[2:0]));
    chk("sreq", int'(sample_req), int'(e[3]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int ch, input int data);
    wr_valid = 1'b1; wr_ch = 2'(ch); wr_data = 8'(data);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_sreq(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_req && n < 20);
    if (!sample_req) chk("sreq_timeout", 0, 1);
  endtask

  task automatic count_ones(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      c0 += int'(pdm[0]); c1 += int'(pdm[1]);
    end
  endtask

  task automatic reset_and_first_ticks();
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("sreq_period", int'(sample_req), (i == 1 || i == 5 || i == 9) ? 1 : 0);
    end
  endtask

  initial begin
    int n, c0, c1;
    #1 rst = 1'b1;
    #2;
    chk("rst_pdm", int'(pdm), 0);
    chk("rst_sreq", int'(sample_req), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_pdm", int'(pdm), 0);
    rst = 1'b0;
    model_reset();
    reset_and_first_ticks();
    // density: duty 0x00 -> half, 0x40 -> three quarters
    div = 4'd0;
    wr(0, 8'h00);
    wr(1, 8'h40);
    steps(10);
    count_ones(c0, c1);
    chk("dens_ch0", c0, 128);
    chk("dens_ch1", c1, 192);
    // extremes
    wr(0, 8'h80);
    wr(1, 8'h7F);
    steps(4);
    count_ones(c0, c1);
    chk("ext_ch0", c0, 0);
    chk("ext_ch1", c1, 255);
    // commit alignment with a write coincident with a tick
    div = 4'd7;
    wait_sreq(n);
    wait_sreq(n);
    steps(2);
    wr(0, 8'hC0);
    step();
    wr(1, 8'h20);
    n = 0;
    while (m_cnt != m_divq && n < 20) begin
      step();
      n++;
    end
    wr(0, 8'h10);
    steps(24);
    // divider change mid-period, and a write to a missing channel
    div = 4'd3;
    wait_sreq(n);
    wait_sreq(n);
    chk("div3_gap", n, 4);
    wr(1, 8'h7F);
    wait_sreq(n);
    div = 4'd1;
    wr_valid = 1'b1; wr_ch = 2'd3; wr_data = 8'h55;
    wait_sreq(n);
    chk("div_change_gap", n, 4);
    wr_valid = 1'b0;
    wait_sreq(n);
    chk("div1_gap_a", n, 2);
    wait_sreq(n);
    chk("div1_gap_b", n, 2);
    steps(8);
    // mute ch1 for 10 clocks
    en[1] = 1'b0;
    step();
    chk("mute_next", int'(pdm[1]), 0);
    steps(9);
    en[1] = 1'b1;
    steps(12);
    // asynchronous reset mid-period
    wait_sreq(n);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pdm", int'(pdm), 0);
    chk("async_rst_sreq", int'(sample_req), 0);
    div = 4'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    reset_and_first_ticks();
    steps(8);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
